// File: rtl/nbody_pkg.sv
// Shared definitions for the n-body pipeline: data width, acceleration-stage
// latency, sequencer states and the per-pair tag carried alongside results.
package nbody_pkg;

  localparam int DATA_W = 64;

  // 1 input reg + 20 sub + 11 mult + 20 add + 27 invsqrt + 4x11 mult
  localparam int ACCL_PIPE_LAT = 1 + 20 + 11 + 20 + 27 + 4 * 11;

  localparam int NB_N_MAX = 64;
  localparam int NB_IDX_W = $clog2(NB_N_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic                valid;
    logic [NB_IDX_W-1:0] idx;
    logic                first;
    logic                last;
  } pair_tag_t;

endpackage

// File: rtl/pair_sequencer_tag_delay.sv
// Fixed-depth, never-stalled shift register for pair tags; every stage is
// cleared by the synchronous active-low reset.
module tag_delay
  import nbody_pkg::*;
#(
  parameter int DEPTH = ACCL_PIPE_LAT
) (
  input  logic      clk,
  input  logic      rst,
  input  pair_tag_t tag_in,
  output pair_tag_t tag_out
);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      pair_tag_t q_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst) q_reg <= '0;
          else      q_reg <= tag_in;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (!rst) q_reg <= '0;
          else      q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign tag_out = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/pair_sequencer.sv
// Walks all ordered (i, j) body pairs, fetches both bodies from RAM and issues
// one operand set per cycle, with a tag delayed to line up with the results.
module pair_sequencer
  import nbody_pkg::*;
#(
  parameter int N_MAX    = NB_N_MAX,
  parameter int IDX_W    = $clog2(N_MAX),
  parameter int PIPE_LAT = ACCL_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W:0]    n_bodies,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rd_addr_i,
  input  logic [DATA_W-1:0] rd_x_i,
  input  logic [DATA_W-1:0] rd_y_i,
  output logic [IDX_W-1:0]  rd_addr_j,
  input  logic [DATA_W-1:0] rd_x_j,
  input  logic [DATA_W-1:0] rd_y_j,
  input  logic [DATA_W-1:0] rd_m_j,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] m2,
  output logic              issue_valid,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_i,
  output logic              out_first,
  output logic              out_last
);

  seq_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  i_reg, i_next;
  logic [IDX_W-1:0]  j_reg, j_next;
  logic [IDX_W:0]    n_reg, n_next;
  logic              done_next;

  pair_tag_t         s1_tag_reg, s1_tag_next;
  pair_tag_t         issue_tag_reg;
  pair_tag_t         out_tag;
  logic [DATA_W-1:0] x1_reg, y1_reg, x2_reg, y2_reg, m2_reg;

  logic              addr_valid;
  logic              j_last, i_last;
  logic [IDX_W:0]    n_clamped;
  logic              tag_hit;

  assign n_clamped  = (n_bodies > (IDX_W+1)'(N_MAX)) ? (IDX_W+1)'(N_MAX) : n_bodies;
  assign j_last     = ({1'b0, j_reg} == n_reg - 1'b1);
  assign i_last     = ({1'b0, i_reg} == n_reg - 1'b1);
  assign addr_valid = (state_reg == ST_RUN) && !hold;
  assign tag_hit    = out_tag.valid && out_tag.last &&
                      ((IDX_W+1)'(out_tag.idx) == n_reg - 1'b1);

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    n_next     = n_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          n_next     = n_clamped;
          i_next     = '0;
          j_next     = '0;
          // An empty run skips straight to the completion check.
          state_next = (n_clamped == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          if (j_last) begin
            j_next = '0;
            if (i_last) begin
              i_next     = '0;
              state_next = ST_DRAIN;
            end else begin
              i_next = i_reg + 1'b1;
            end
          end else begin
            j_next = j_reg + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if ((n_reg == '0) || tag_hit) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s1_tag_next = '0;
    if (addr_valid) begin
      s1_tag_next.valid = 1'b1;
      s1_tag_next.idx   = NB_IDX_W'(i_reg);
      s1_tag_next.first = (j_reg == '0);
      s1_tag_next.last  = j_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      i_reg         <= '0;
      j_reg         <= '0;
      n_reg         <= '0;
      s1_tag_reg    <= '0;
      issue_tag_reg <= '0;
      x1_reg        <= '0;
      y1_reg        <= '0;
      x2_reg        <= '0;
      y2_reg        <= '0;
      m2_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      i_reg         <= i_next;
      j_reg         <= j_next;
      n_reg         <= n_next;
      s1_tag_reg    <= s1_tag_next;
      issue_tag_reg <= s1_tag_reg;
      // Bubbles present zero operands: a massless self-pair downstream.
      x1_reg        <= s1_tag_reg.valid ? rd_x_i : '0;
      y1_reg        <= s1_tag_reg.valid ? rd_y_i : '0;
      x2_reg        <= s1_tag_reg.valid ? rd_x_j : '0;
      y2_reg        <= s1_tag_reg.valid ? rd_y_j : '0;
      m2_reg        <= s1_tag_reg.valid ? rd_m_j : '0;
    end
  end

  tag_delay #(
    .DEPTH (PIPE_LAT)
  ) u_tag_delay (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (issue_tag_reg),
    .tag_out (out_tag)
  );

  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_next;
  assign rd_addr_i   = i_reg;
  assign rd_addr_j   = j_reg;
  assign x1          = x1_reg;
  assign y1          = y1_reg;
  assign x2          = x2_reg;
  assign y2          = y2_reg;
  assign m2          = m2_reg;
  assign issue_valid = issue_tag_reg.valid;
  assign out_valid   = out_tag.valid;
  assign out_i       = IDX_W'(out_tag.idx);
  assign out_first   = out_tag.first;
  assign out_last    = out_tag.last;

endmodule

// File: tb/tb_pair_sequencer.sv
// Bench for pair_sequencer: a cycle-indexed schedule of expected issues and
// results, derived from pair order and fixed latencies, checked every cycle.
module tb_pair_sequencer;

  localparam int NMAX = 64;
  localparam int IW   = 6;
  localparam int LAT  = 123;
  localparam int NEVER = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst, start, hold;
  logic [IW:0]   n_bodies;
  logic          busy, done;
  logic [IW-1:0] rd_addr_i, rd_addr_j;
  logic [63:0]   rd_x_i, rd_y_i, rd_x_j, rd_y_j, rd_m_j;
  logic [63:0]   x1, y1, x2, y2, m2;
  logic          issue_valid, out_valid, out_first, out_last;
  logic [IW-1:0] out_i;

  pair_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .n_bodies(n_bodies), .hold(hold),
    .busy(busy), .done(done),
    .rd_addr_i(rd_addr_i), .rd_x_i(rd_x_i), .rd_y_i(rd_y_i),
    .rd_addr_j(rd_addr_j), .rd_x_j(rd_x_j), .rd_y_j(rd_y_j), .rd_m_j(rd_m_j),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .m2(m2),
    .issue_valid(issue_valid), .out_valid(out_valid), .out_i(out_i),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Body RAM with one-cycle registered reads on both ports
  logic [63:0] ram_x [NMAX];
  logic [63:0] ram_y [NMAX];
  logic [63:0] ram_m [NMAX];
  always @(posedge clk) begin
    rd_x_i <= ram_x[rd_addr_i];
    rd_y_i <= ram_y[rd_addr_i];
    rd_x_j <= ram_x[rd_addr_j];
    rd_y_j <= ram_y[rd_addr_j];
    rd_m_j <= ram_m[rd_addr_j];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Reference model: expected issue/result contents keyed by cycle number
  bit m_active = 0;
  int m_n, m_k, m_done_cyc = NEVER;
  int iss_i [int];
  int iss_j [int];
  int ot_i [int];
  int ot_f [int];
  int ot_l [int];

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      m_active = 0;
      m_done_cyc = NEVER;
      iss_i.delete(); iss_j.delete();
      ot_i.delete(); ot_f.delete(); ot_l.delete();
    end else if (!m_active) begin
      if (start === 1'b1) begin
        m_active = 1;
        m_n = (int'(n_bodies) > NMAX) ? NMAX : int'(n_bodies);
        m_k = 0;
        m_done_cyc = (m_n == 0) ? cyc + 1 : NEVER;
      end
    end else if (cyc == m_done_cyc) begin
      m_active = 0;
    end else if (m_k < m_n * m_n && hold === 1'b0) begin
      // this cycle addresses pair m_k
      iss_i[cyc + 2] = m_k / m_n;
      iss_j[cyc + 2] = m_k % m_n;
      ot_i[cyc + 2 + LAT] = m_k / m_n;
      ot_f[cyc + 2 + LAT] = (m_k % m_n == 0) ? 1 : 0;
      ot_l[cyc + 2 + LAT] = (m_k % m_n == m_n - 1) ? 1 : 0;
      m_k++;
      if (m_k == m_n * m_n) m_done_cyc = cyc + 2 + LAT;
    end
    cyc++;
  end

  // Per-cycle comparison plus per-run statistics
  logic        e_busy, e_done, e_iv, e_ov, e_f, e_l;
  logic [63:0] ex1, ey1, ex2, ey2, em2;
  logic [IW-1:0] e_oi;
  int run_issues, out_cnt, done_seen_cyc;
  logic [63:0] cap_x1, cap_y1, cap_x2, cap_m2;

  always @(negedge clk) begin
    if (chk_en) begin
      e_busy = m_active;
      e_done = m_active && (cyc == m_done_cyc);
      checks++;
      if (busy !== e_busy || done !== e_done) begin
        errors++;
        $display("FAIL ctrl cyc=%0d busy=%b done=%b required busy=%b done=%b",
                 cyc, busy, done, e_busy, e_done);
      end

      e_iv = 0; ex1 = 0; ey1 = 0; ex2 = 0; ey2 = 0; em2 = 0;
      if (iss_i.exists(cyc)) begin
        e_iv = 1;
        ex1 = ram_x[iss_i[cyc]]; ey1 = ram_y[iss_i[cyc]];
        ex2 = ram_x[iss_j[cyc]]; ey2 = ram_y[iss_j[cyc]]; em2 = ram_m[iss_j[cyc]];
        iss_i.delete(cyc); iss_j.delete(cyc);
      end
      checks++;
      if (issue_valid !== e_iv || x1 !== ex1 || y1 !== ey1 || x2 !== ex2 ||
          y2 !== ey2 || m2 !== em2) begin
        errors++;
        $display("FAIL issue cyc=%0d got v=%b x1=%h y1=%h x2=%h y2=%h m2=%h required v=%b x1=%h y1=%h x2=%h y2=%h m2=%h",
                 cyc, issue_valid, x1, y1, x2, y2, m2, e_iv, ex1, ey1, ex2, ey2, em2);
      end

      e_ov = 0; e_oi = 0; e_f = 0; e_l = 0;
      if (ot_i.exists(cyc)) begin
        e_ov = 1; e_oi = IW'(ot_i[cyc]); e_f = ot_f[cyc][0]; e_l = ot_l[cyc][0];
        ot_i.delete(cyc); ot_f.delete(cyc); ot_l.delete(cyc);
      end
      checks++;
      if (out_valid !== e_ov || out_i !== e_oi || out_first !== e_f || out_last !== e_l) begin
        errors++;
        $display("FAIL tag cyc=%0d got v=%b i=%0d f=%b l=%b required v=%b i=%0d f=%b l=%b",
                 cyc, out_valid, out_i, out_first, out_last, e_ov, e_oi, e_f, e_l);
      end

      if (issue_valid === 1'b1) begin
        if (run_issues == 4) begin
          cap_x1 = x1; cap_y1 = y1; cap_x2 = x2; cap_m2 = m2;
        end
        run_issues++;
      end
      if (out_valid === 1'b1) out_cnt++;
      if (done === 1'b1) done_seen_cyc = cyc;
    end
  end

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic fill_ram(input bit random_data);
    for (int k = 0; k < NMAX; k++) begin
      if (random_data) begin
        ram_x[k] = {$urandom, $urandom};
        ram_y[k] = {$urandom, $urandom};
        ram_m[k] = {$urandom, $urandom};
      end else begin
        ram_x[k] = 64'(k);
        ram_y[k] = 64'(2 * k);
        ram_m[k] = 64'(10 + k);
      end
    end
  endtask

  // kind: 0 plain, 1 hold in c0+6..c0+7, 2 random hold, 3 random start pulses
  task automatic run(input string name, input int nb, input int kind,
                     input int exp_issues, input int exp_lat);
    int c0;
    bit got;
    run_issues = 0; out_cnt = 0; done_seen_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; n_bodies = (IW+1)'(nb); c0 = cyc;
    got = 0;
    for (int t = 0; t < 8000 && !got; t++) begin
      @(posedge clk); #1;
      if (done_seen_cyc >= 0) begin
        got = 1; start = 1'b0; hold = 1'b0;
      end else begin
        start = (kind == 3) ? ($urandom_range(0, 15) == 0) : 1'b0;
        hold  = (kind == 1) ? (cyc == c0 + 6 || cyc == c0 + 7) :
                (kind == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
    start = 1'b0; hold = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout got no done required done", name);
      rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
    end else begin
      check_int({name, "_issues"}, run_issues, exp_issues);
      check_int({name, "_results"}, out_cnt, exp_issues);
      if (exp_lat >= 0) check_int({name, "_done_lat"}, done_seen_cyc - c0, exp_lat);
    end
    $display("run %s n=%0d kind=%0d c0=%0d done_lat=%0d issues=%0d results=%0d",
             name, nb, kind, c0, done_seen_cyc - c0, run_issues, out_cnt);
  endtask

  initial begin
    int nb;
    rst = 1'b0; start = 1'b0; hold = 1'b0; n_bodies = '0;
    fill_ram(1'b0);
    @(posedge clk); chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check_int("reset_outputs",
              int'({busy, done, issue_valid, out_valid, out_first, out_last}) +
              int'(x1 != 0) + int'(m2 != 0) + int'(rd_addr_i) + int'(rd_addr_j) + int'(out_i), 0);
    rst = 1'b1;

    run("n3", 3, 0, 9, 134);
    check_int("n3_issue4_x1", int'(cap_x1), 1);
    check_int("n3_issue4_y1", int'(cap_y1), 2);
    check_int("n3_issue4_x2", int'(cap_x2), 1);
    check_int("n3_issue4_m2", int'(cap_m2), 11);
    run("n3_hold", 3, 1, 9, 136);
    run("n0", 0, 0, 0, 1);
    run("n1", 1, 0, 1, 126);

    // reset in the middle of a run
    @(posedge clk); #1; start = 1'b1; n_bodies = 7'd5;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    out_cnt = 0; done_seen_cyc = -1;
    repeat (130) @(posedge clk);
    #1;
    check_int("abort_results", out_cnt, 0);
    check_int("abort_done", done_seen_cyc, -1);
    $display("run abort n=5 results=%0d", out_cnt);
    fill_ram(1'b0);
    run("after_abort", 2, 0, 4, 129);

    for (int r = 0; r < 8; r++) begin
      fill_ram(1'b1);
      nb = $urandom_range(0, 12);
      run("random", nb, (r % 2 == 0) ? 2 : 3, nb * nb, -1);
    end

    fill_ram(1'b1);
    run("clamp", 100, 3, 4096, 4096 + LAT + 2);
    run("clamp_hold", 70, 2, 4096, -1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pair_sequencer.md
Name: pair_sequencer

Overview:
- Upstream feeder for the pairwise acceleration pipeline. For a run of N bodies, walks every (i, j) ordered pair, i outer and j inner, i==j included. It reads body state from the body RAM and presents one pair per cycle to the acceleration stage's x1/y1/x2/y2/m2 inputs.
- Carries an aligned tag (i index, first-of-row, last-of-row) through a PIPE_LAT-deep delay line. The downstream accumulator can then attribute each ax/ay result to body i without knowing the pipeline depth.

Parameters:
- N_MAX, 64, maximum body count supported by the RAM.
- IDX_W, $clog2(N_MAX), body index width.
- PIPE_LAT, 123, latency of the acceleration stage: 1 input reg + 20 sub + 11 mult + 20 add + 27 invsqrt + 4x11 mult.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-low (asserted when rst==0)
- start  in  1  begin run; sampled only when idle
- n_bodies  in  IDX_W+1  body count for this run
- hold  in  1  pause issuing new pairs
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- rd_addr_i  out  IDX_W  RAM port A address (body i)
- rd_x_i, rd_y_i  in  64  port A data, 1-cycle read latency
- rd_addr_j  out  IDX_W  RAM port B address (body j)
- rd_x_j, rd_y_j, rd_m_j  in  64  port B data, 1-cycle latency; mass pre-multiplied by G
- x1, y1, x2, y2, m2  out  64  pair operands to the acceleration stage
- issue_valid  out  1  pair operands valid this cycle
- out_valid  out  1  tag valid; aligned with the acceleration stage's ax/ay
- out_i  out  IDX_W  body index of the result
- out_first, out_last  out  1  result is j==0 / j==n-1 of its row

Behaviour:
- Reset (rst==0 at posedge): state IDLE; counters 0; all outputs 0, including every stage of the tag delay line. Reset mid-run aborts the run with no done pulse. out_valid is 0 from the next cycle.
- FSM IDLE -> RUN -> DRAIN -> IDLE.
- IDLE: start==1 sampled in cycle c0 latches n = min(n_bodies, N_MAX) and sets busy. start is ignored while busy.
- n==0: no pairs issued; done pulses in c0+1; busy drops with it.
- RUN: each cycle with hold==0, drives rd_addr_i=i and rd_addr_j=j, marks stage-1 valid, then advances j. When j wraps from n-1 to 0, it increments i. Once pair (n-1, n-1) is addressed, goes to DRAIN.
- RUN with hold==1: addresses and counters frozen; stage-1 valid is 0, so a bubble enters the pipeline. hold is ignored outside RUN.
- Stage 2 (cycle after addressing): RAM data returns. At the end of that cycle, data is registered into x1..m2 and issue_valid is set. Pair k (no holds) is issued in cycle c0+3+k.
- When issue_valid==0, x1..m2 are driven to 0. The acceleration stage treats this as a self-pair with zero mass, which is harmless.
- Tag {valid, i, j==0, j==n-1} is captured with the operands and delayed exactly PIPE_LAT cycles to out_*. The line is a plain shift register, never stalled.
- DRAIN: waits for a tag with out_valid && out_last && out_i==n-1. done pulses in that same cycle; busy falls; returns to IDLE.
- With no holds, done occurs at cycle c0 + n*n + PIPE_LAT + 2. Each held cycle adds exactly one cycle.
- n==1: a single pair (0, 0) with out_first==out_last==1.
- All arithmetic is index counting only; no floating-point handling here.

Decomposition:
- Shared package nbody_pkg: DATA_W=64, ACCL_PIPE_LAT=123 (the sum above, kept beside the acceleration stage's timing parameters), and typedef pair_tag_t {valid, idx, first, last}.
- One sub-module: tag_delay, a parameterised shift register of pair_tag_t with synchronous active-low clear.

Test Plan:
- n_bodies=3, no hold, RAM x=k, y=2k, m=10+k -> 9 issues in c0+3..c0+11. Order (0,0),(0,1),(0,2),(1,0)...(2,2). Issue 4 is x1=1, x2=1, m2=11. out_valid in c0+126..c0+134; done at c0+134.
- n_bodies=3, hold high for 2 cycles after pair 4 is addressed -> bubble of 2 at issue_valid and out_valid; order preserved; done at c0+136.
- n_bodies=0 -> no issue_valid; done pulse at c0+1; busy high for one cycle only.
- n_bodies=1 -> single issue at c0+3 with first=last=1, out_i=0; done at c0+126.
- start pulsed again mid-run -> ignored; pair count stays n*n. n_bodies=100 with N_MAX=64 -> clamped to 64; 4096 issues.
- rst low for 1 cycle mid-RUN -> next cycle all outputs 0, out_valid stays 0 for 123+ cycles, no done. A new start then runs cleanly.
